// File: rtl/seq_restoring_divider.sv
// Sequential restoring divider: unsigned N-bit / M-bit, one quotient bit per clock,
// start/busy/done handshake with a divide-by-zero flag.
module seq_restoring_divider #(
  parameter int N = 8,
  parameter int M = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [M-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic         div_zero,
  output logic [N-1:0] quotient,
  output logic [M-1:0] remainder
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, state_nxt;
  logic [M-1:0]  d;
  logic [M-1:0]  r, r_nxt;
  logic [N-1:0]  q, q_nxt;
  logic [CW-1:0] cnt;
  logic [M:0]    t;
  logic          fits, last, accept;

  // R stays below D after every step, so it is held in M bits; T needs M+1.
  always_comb begin
    t      = {r, q[N-1]};
    fits   = t >= {1'b0, d};
    r_nxt  = fits ? M'(t - {1'b0, d}) : M'(t);
    q_nxt  = (q << 1) | N'(fits);
    last   = cnt == '0;
    accept = start && (state != RUN);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE, DONE: begin
        if (start) state_nxt = (divisor == '0) ? DONE : RUN;
        else       state_nxt = IDLE;
      end
      RUN:     if (last) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy = state == RUN;
    done = state == DONE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      d         <= '0;
      r         <= '0;
      q         <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else if (accept) begin
      if (divisor != '0) begin
        d   <= divisor;
        r   <= '0;
        q   <= dividend;
        cnt <= CW'(N - 1);
      end else begin
        quotient  <= '1;
        remainder <= '0;
        div_zero  <= 1'b1;
      end
    end else if (state == RUN) begin
      r   <= r_nxt;
      q   <= q_nxt;
      cnt <= cnt - 1'b1;
      // Results are published only on the final step, i.e. on DONE entry.
      if (last) begin
        quotient  <= q_nxt;
        remainder <= r_nxt;
        div_zero  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_seq_restoring_divider.sv
// Bench for seq_restoring_divider: directed spec cases plus random operands,
// checked against plain integer division.
module tb_seq_restoring_divider;
  localparam int N = 8;
  localparam int M = 4;

  logic         clk = 1'b0;
  logic         rst, start;
  logic [N-1:0] dividend;
  logic [M-1:0] divisor;
  logic         busy, done, div_zero;
  logic [N-1:0] quotient;
  logic [M-1:0] remainder;

  int errors = 0;
  int checks = 0;

  seq_restoring_divider #(.N(N), .M(M)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .div_zero(div_zero),
    .quotient(quotient), .remainder(remainder)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present operands for one edge (the accepting edge), then scramble the inputs
  // so a design that resamples them mid-divide gives a wrong answer.
  task automatic launch(input logic [N-1:0] a, input logic [M-1:0] b);
    start = 1'b1; dividend = a; divisor = b;
    tick();
    start = 1'b0; dividend = N'($urandom); divisor = M'($urandom);
  endtask

  // Wait for done; 'elapsed' cycles since the accepting edge were already spent.
  task automatic finish_div(input string tag, input logic [N-1:0] a, input logic [M-1:0] b,
                            input int elapsed);
    int lat;
    int exp_q, exp_r, exp_lat;
    bit exp_dz;
    lat = elapsed;
    while (!done && lat < 40) begin
      tick();
      lat++;
    end
    if (b == 0) begin
      exp_q = (1 << N) - 1; exp_r = 0; exp_dz = 1'b1; exp_lat = 0;
    end else begin
      exp_q = int'(a) / int'(b); exp_r = int'(a) % int'(b); exp_dz = 1'b0; exp_lat = N;
    end
    chk({tag, ".lat"}, lat, exp_lat);
    chk({tag, ".q"}, quotient, exp_q);
    chk({tag, ".r"}, remainder, exp_r);
    chk({tag, ".dz"}, div_zero, exp_dz);
  endtask

  task automatic run_div(input string tag, input logic [N-1:0] a, input logic [M-1:0] b);
    launch(a, b);
    chk({tag, ".busy"}, busy, b != 0);
    finish_div(tag, a, b, 0);
  endtask

  // One idle edge after a done: the pulse must have dropped.
  task automatic gap(input string tag);
    tick();
    chk({tag, ".pulse"}, done, 1'b0);
  endtask

  initial begin
    int seen;
    logic [N-1:0] ra;
    logic [M-1:0] rb;
    rst = 1'b1; start = 1'b0; dividend = '0; divisor = '0;
    tick(); tick();
    chk("rst.busy", busy, 0);
    chk("rst.done", done, 0);
    chk("rst.q", quotient, 0);
    chk("rst.r", remainder, 0);
    chk("rst.dz", div_zero, 0);
    rst = 1'b0;
    tick();

    run_div("200/7", 8'd200, 4'd7);   gap("200/7");
    run_div("255/15", 8'd255, 4'd15); gap("255/15");
    run_div("255/1", 8'd255, 4'd1);   gap("255/1");
    run_div("5/9", 8'd5, 4'd9);       gap("5/9");
    run_div("13/0", 8'd13, 4'd0);     gap("13/0");
    run_div("13/2", 8'd13, 4'd2);     gap("13/2");
    run_div("0/3", 8'd0, 4'd3);       gap("0/3");

    // A start while busy must be ignored.
    launch(8'd100, 4'd3);
    tick(); tick();
    start = 1'b1; dividend = 8'd50; divisor = 4'd5;
    tick();
    start = 1'b0;
    chk("ign.busy", busy, 1);
    finish_div("100/3", 8'd100, 4'd3, 3);
    gap("100/3");

    // Reset mid-divide aborts it with no done pulse.
    launch(8'd90, 4'd4);
    tick(); tick(); tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("abort.busy", busy, 0);
    chk("abort.done", done, 0);
    chk("abort.q", quotient, 0);
    chk("abort.r", remainder, 0);
    chk("abort.dz", div_zero, 0);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done) seen++;
    end
    chk("abort.nodone", seen, 0);

    // Back-to-back: each new start is presented in the DONE cycle.
    run_div("90/4", 8'd90, 4'd4);
    chk("b2b.done", done, 1);
    run_div("b2b.0", 8'd77, 4'd0);
    run_div("b2b.200/13", 8'd200, 4'd13);
    gap("b2b");

    for (int i = 0; i < 24; i++) begin
      ra = N'($urandom);
      rb = (i % 6 == 5) ? 4'd0 : M'($urandom);
      run_div($sformatf("rnd%0d", i), ra, rb);
      if (i % 3 == 0) gap($sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
